// File: rtl/rx_status_monitor_if.sv
// PIPE receiver-status and detection handshake bundle between the PHY/MAC side and rx_status_monitor.
// slave is the monitor's view; master is the driving side.
interface rx_status_monitor_if #(
   parameter int CNT_W = 8
) ();
   logic [2:0]       rx_status;
   logic             rx_valid;
   logic             phy_status;
   logic             det_start;
   logic             clr;
   logic             tx_detect_rx;
   logic             det_done;
   logic             det_result;
   logic             det_timeout;
   logic [6:0]       sticky;
   logic [CNT_W-1:0] skip_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic             irq;

   modport slave (
      input  rx_status, rx_valid, phy_status, det_start, clr,
      output tx_detect_rx, det_done, det_result, det_timeout,
             sticky, skip_cnt, err_cnt, irq
   );

   modport master (
      output rx_status, rx_valid, phy_status, det_start, clr,
      input  tx_detect_rx, det_done, det_result, det_timeout,
             sticky, skip_cnt, err_cnt, irq
   );
endinterface

// File: rtl/rx_status_monitor.sv
// Decodes PIPE RxStatus into sticky flags and saturating counters, and runs
// the TxDetectRx receiver-detection handshake with a timeout.
//
// state  | meaning
// IDLE   | waiting for det_start
// DETECT | tx_detect_rx high, waiting for phy_status or timeout
// DONE   | one-cycle det_done pulse, then back to IDLE
module rx_status_monitor #(
   parameter int CNT_W       = 8,
   parameter int DET_TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   rx_status_monitor_if.slave bus
);

   localparam logic [15:0]      TIMER_TC = 16'(DET_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [2:0]       CODE_RX_DET = 3'b011;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DETECT = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] timer, timer_nxt;
   logic        det_result_q, det_result_nxt;
   logic        det_timeout_q, det_timeout_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         timer         <= '0;
         det_result_q  <= 1'b0;
         det_timeout_q <= 1'b0;
      end else begin
         state         <= state_nxt;
         timer         <= timer_nxt;
         det_result_q  <= det_result_nxt;
         det_timeout_q <= det_timeout_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      timer_nxt       = timer;
      det_result_nxt  = det_result_q;
      det_timeout_nxt = det_timeout_q;
      case (state)
         IDLE: begin
            if (bus.det_start) begin
               state_nxt       = DETECT;
               timer_nxt       = '0;
               det_result_nxt  = 1'b0;
               det_timeout_nxt = 1'b0;
            end
         end
         DETECT: begin
            // phy_status takes precedence over a timeout landing in the same cycle
            if (bus.phy_status) begin
               state_nxt       = DONE;
               det_result_nxt  = (bus.rx_status == CODE_RX_DET);
               det_timeout_nxt = 1'b0;
            end else if (timer == TIMER_TC) begin
               state_nxt       = DONE;
               det_result_nxt  = 1'b0;
               det_timeout_nxt = 1'b1;
            end else begin
               timer_nxt = timer + 16'd1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.tx_detect_rx = (state == DETECT);
   assign bus.det_done     = (state == DONE);
   assign bus.det_result   = det_result_q;
   assign bus.det_timeout  = det_timeout_q;

   logic [6:0]       sticky_q;
   logic [6:0]       set_mask;
   logic [CNT_W-1:0] skip_q, err_q;
   logic             is_skip, is_err;

   always_comb begin
      set_mask = '0;
      if (bus.rx_status != 3'b000) begin
         set_mask[bus.rx_status - 3'd1] = 1'b1;
      end
   end

   assign is_skip = (bus.rx_status == 3'b001) || (bus.rx_status == 3'b010);
   assign is_err  = bus.rx_status[2];

   // clr drops any code presented in the same cycle
   always_ff @(posedge clk) begin
      if (rst || bus.clr) begin
         sticky_q <= '0;
         skip_q   <= '0;
         err_q    <= '0;
      end else if (bus.rx_valid) begin
         sticky_q <= sticky_q | set_mask;
         if (is_skip && (skip_q != CNT_MAX)) begin
            skip_q <= skip_q + 1'b1;
         end
         if (is_err && (err_q != CNT_MAX)) begin
            err_q <= err_q + 1'b1;
         end
      end
   end

   assign bus.sticky   = sticky_q;
   assign bus.skip_cnt = skip_q;
   assign bus.err_cnt  = err_q;
   assign bus.irq      = |sticky_q[6:3];

endmodule

// File: tb/tb_rx_status_monitor.sv
// Bench for rx_status_monitor: vector table for the monitor path, hand-written
// detection sequences, and randomized traffic against a rule-level reference model.
module tb_rx_status_monitor;

   localparam int CNT_W = 8;
   localparam int TMO   = 16;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rx_status_monitor_if #(.CNT_W(CNT_W)) bus ();

   rx_status_monitor #(.CNT_W(CNT_W), .DET_TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      bit       clr;
      bit       valid;
      bit [2:0] code;
      int       skip;
      int       err;
      bit [6:0] sticky;
      bit       irq;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.rx_status  = 3'b000;
      bus.rx_valid   = 1'b0;
      bus.phy_status = 1'b0;
      bus.det_start  = 1'b0;
      bus.clr        = 1'b0;
   endtask

   // Detection transaction: phy_cycle = DETECT cycle (1-based) carrying phy_status,
   // 0 = never. busy = hold det_start high while the FSM is not idle.
   task automatic run_detect(input string nm, input int phy_cycle, input bit [2:0] code,
                             input bit busy);
      int tx_cnt, done_cnt, exp_tx;
      bit exp_res, exp_tmo;
      if (phy_cycle >= 1 && phy_cycle <= TMO) begin
         exp_tx  = phy_cycle;
         exp_res = (code == 3'b011);
         exp_tmo = 1'b0;
      end else begin
         exp_tx  = TMO;
         exp_res = 1'b0;
         exp_tmo = 1'b1;
      end
      bus.det_start = 1'b1;
      tick();
      bus.det_start = 1'b0;
      chk({nm, " result_cleared"}, int'(bus.det_result), 0);
      chk({nm, " timeout_cleared"}, int'(bus.det_timeout), 0);
      tx_cnt = 0;
      done_cnt = 0;
      for (int k = 0; k < TMO + 12; k++) begin
         if (bus.tx_detect_rx) tx_cnt++;
         if (bus.det_done) done_cnt++;
         bus.phy_status = bus.tx_detect_rx && (tx_cnt == phy_cycle);
         bus.rx_status  = bus.phy_status ? code : 3'b011;
         bus.det_start  = busy && (bus.tx_detect_rx || bus.det_done);
         tick();
      end
      idle_inputs();
      chk({nm, " tx_cycles"}, tx_cnt, exp_tx);
      chk({nm, " done_pulses"}, done_cnt, 1);
      chk({nm, " det_result"}, int'(bus.det_result), int'(exp_res));
      chk({nm, " det_timeout"}, int'(bus.det_timeout), int'(exp_tmo));
   endtask

   initial begin
      int m_skip, m_err, done_seen, pc;
      bit [6:0] m_sticky;
      bit [2:0] c;
      bit v, cl;

      vecs[0]  = '{0, 1, 3'b001, 1, 0, 7'b0000001, 0};
      vecs[1]  = '{0, 1, 3'b010, 2, 0, 7'b0000011, 0};
      vecs[2]  = '{0, 1, 3'b100, 2, 1, 7'b0001011, 1};
      vecs[3]  = '{0, 1, 3'b111, 2, 2, 7'b1001011, 1};
      vecs[4]  = '{0, 0, 3'b101, 2, 2, 7'b1001011, 1};
      vecs[5]  = '{0, 1, 3'b000, 2, 2, 7'b1001011, 1};
      vecs[6]  = '{0, 1, 3'b011, 2, 2, 7'b1001111, 1};
      vecs[7]  = '{1, 1, 3'b100, 0, 0, 7'b0000000, 0};
      vecs[8]  = '{0, 1, 3'b101, 0, 1, 7'b0010000, 1};
      vecs[9]  = '{0, 1, 3'b110, 0, 2, 7'b0110000, 1};
      vecs[10] = '{1, 0, 3'b000, 0, 0, 7'b0000000, 0};
      vecs[11] = '{0, 1, 3'b011, 0, 0, 7'b0000100, 0};

      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("reset sticky", int'(bus.sticky), 0);
      chk("reset skip", int'(bus.skip_cnt), 0);
      chk("reset err", int'(bus.err_cnt), 0);
      chk("reset irq", int'(bus.irq), 0);
      chk("reset tx", int'(bus.tx_detect_rx), 0);
      chk("reset done", int'(bus.det_done), 0);

      for (int i = 0; i < 12; i++) begin
         bus.clr       = vecs[i].clr;
         bus.rx_valid  = vecs[i].valid;
         bus.rx_status = vecs[i].code;
         tick();
         chk($sformatf("vec%0d skip", i), int'(bus.skip_cnt), vecs[i].skip);
         chk($sformatf("vec%0d err", i), int'(bus.err_cnt), vecs[i].err);
         chk($sformatf("vec%0d sticky", i), int'(bus.sticky), int'(vecs[i].sticky));
         chk($sformatf("vec%0d irq", i), int'(bus.irq), int'(vecs[i].irq));
      end
      idle_inputs();

      // Saturation then clr beating a simultaneous valid code
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      bus.rx_valid  = 1'b1;
      bus.rx_status = 3'b110;
      for (int i = 0; i < 300; i++) tick();
      chk("sat err", int'(bus.err_cnt), CMAX);
      chk("sat skip", int'(bus.skip_cnt), 0);
      bus.clr = 1'b1;
      bus.rx_status = 3'b100;
      tick();
      idle_inputs();
      chk("clr err", int'(bus.err_cnt), 0);
      chk("clr sticky", int'(bus.sticky), 0);
      chk("clr irq", int'(bus.irq), 0);

      run_detect("present", 4, 3'b011, 0);
      run_detect("absent", 4, 3'b000, 0);
      run_detect("timeout", 0, 3'b011, 0);
      run_detect("phy_at_tc", TMO, 3'b011, 0);
      run_detect("busy", 7, 3'b011, 1);
      run_detect("busy_tmo", 0, 3'b000, 1);

      // Reset mid-DETECT
      bus.rx_valid = 1'b1;
      bus.rx_status = 3'b111;
      tick();
      bus.rx_valid = 1'b0;
      bus.det_start = 1'b1;
      tick();
      bus.det_start = 1'b0;
      tick();
      tick();
      chk("pre-rst tx", int'(bus.tx_detect_rx), 1);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("mid-rst tx", int'(bus.tx_detect_rx), 0);
      chk("mid-rst sticky", int'(bus.sticky), 0);
      chk("mid-rst err", int'(bus.err_cnt), 0);
      chk("mid-rst irq", int'(bus.irq), 0);
      chk("mid-rst result", int'(bus.det_result), 0);
      chk("mid-rst timeout", int'(bus.det_timeout), 0);
      done_seen = 0;
      for (int i = 0; i < TMO + 4; i++) begin
         if (bus.det_done || bus.tx_detect_rx) done_seen++;
         tick();
      end
      chk("mid-rst no done", done_seen, 0);
      run_detect("post-rst", 2, 3'b011, 0);

      // Randomized monitor traffic against rule-level model
      m_skip = 0;
      m_err = 0;
      m_sticky = '0;
      bus.clr = 1'b1;
      tick();
      for (int i = 0; i < 3000; i++) begin
         cl = ($urandom_range(0, 199) == 0);
         v  = ($urandom_range(0, 3) != 0);
         c  = 3'($urandom_range(0, 7));
         bus.clr = cl;
         bus.rx_valid = v;
         bus.rx_status = c;
         tick();
         if (cl) begin
            m_skip = 0;
            m_err = 0;
            m_sticky = '0;
         end else if (v) begin
            if (c != 0) m_sticky = m_sticky | 7'(1 << (int'(c) - 1));
            if (c == 1 || c == 2) m_skip = (m_skip < CMAX) ? m_skip + 1 : CMAX;
            if (c >= 4) m_err = (m_err < CMAX) ? m_err + 1 : CMAX;
         end
         chk("rnd skip", int'(bus.skip_cnt), m_skip);
         chk("rnd err", int'(bus.err_cnt), m_err);
         chk("rnd sticky", int'(bus.sticky), int'(m_sticky));
         chk("rnd irq", int'(bus.irq), int'(|m_sticky[6:3]));
      end
      idle_inputs();

      // Randomized detection outcomes; sticky must be untouched by detection
      for (int i = 0; i < 20; i++) begin
         pc = $urandom_range(0, TMO + 4);
         c  = ($urandom_range(0, 1) == 1) ? 3'b011 : 3'($urandom_range(0, 7));
         run_detect($sformatf("rnd_det%0d", i), pc, c, $urandom_range(0, 1) == 1);
         chk("rnd_det sticky", int'(bus.sticky), int'(m_sticky));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
